// File: rtl/muldiv_pkg.sv
// Shared RV32M encodings, FSM state type and width constants for the iterative mul/div unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);

    localparam logic [6:0] OPCODE_COMPUTE  = 7'b0110011;
    localparam logic [6:0] AUX_FUNC_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Decode helper: does this R-type instruction belong to the M extension?
    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_COMPUTE) && (funct7 == AUX_FUNC_MULDIV);
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step on {hi,lo}.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opd_i,
    output logic [XLEN-1:0] hi_c_o,
    output logic [XLEN-1:0] lo_c_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Multiply shifts right consuming multiplier bits from lo; divide shifts left feeding quotient bits into lo.
    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opd_i} : '0);
        shifted = {hi_i, lo_i[XLEN-1]};
        diff    = shifted - {1'b0, opd_i};
        if (is_div_i) begin
            if (!diff[XLEN]) begin
                hi_c_o = diff[XLEN-1:0];
                lo_c_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_c_o = shifted[XLEN-1:0];
                lo_c_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_c_o = sum[XLEN:1];
            lo_c_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are iterated XLEN times, sign applied at the end.
module muldiv_iter_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      func_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        func_q, func_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [XLEN-1:0]   step_hi, step_lo;
    logic              sa, sb;
    logic              div_zero, div_ovf;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   qr_fix;

    muldiv_step u_step (
        .is_div_i (func_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opd_i    (opd_q),
        .hi_c_o   (step_hi),
        .lo_c_o   (step_lo)
    );

    // Effective operand signs: unsigned operands never count as negative.
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        unique case (func_i)
            FUNCT3_MUL, FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM: begin
                sa = opa_i[XLEN-1];
                sb = opb_i[XLEN-1];
            end
            FUNCT3_MULHSU: sa = opa_i[XLEN-1];
            FUNCT3_MULHU, FUNCT3_DIVU, FUNCT3_REMU: ;
            default: ;
        endcase
    end

    assign div_zero = func_i[2] && (opb_i == '0);
    assign div_ovf  = func_i[2] && !func_i[0] && (opa_i == {1'b1, {(XLEN-1){1'b0}}}) && (opb_i == '1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func_d   = func_q;
        neg_d    = neg_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        qr_fix   = neg_if(func_q[1] ? step_hi : step_lo, neg_q);

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    func_d = func_i;
                    cnt_d  = '0;
                    hi_d   = '0;
                    neg_d  = (func_i[2] && func_i[1]) ? sa : (sa ^ sb);
                    if (func_i[2]) begin
                        opd_d = neg_if(opb_i, sb);
                        lo_d  = neg_if(opa_i, sa);
                    end else begin
                        opd_d = neg_if(opa_i, sa);
                        lo_d  = neg_if(opb_i, sb);
                    end
                    busy_d = 1'b1;
                    if (div_zero) begin
                        result_d = func_i[1] ? opa_i : '1;
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                    end else if (div_ovf) begin
                        result_d = func_i[1] ? '0 : opa_i;
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        if (func_q[2]) begin
                            result_d = qr_fix;
                        end else if (func_q == FUNCT3_MUL) begin
                            result_d = prod_fix[XLEN-1:0];
                        end else begin
                            result_d = prod_fix[2*XLEN-1:XLEN];
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            func_q   <= '0;
            neg_q    <= 1'b0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func_q   <= func_d;
            neg_q    <= neg_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit: directed table, corner sequences, random ops vs. arithmetic model.
module tb_muldiv_iter_unit;
    import muldiv_pkg::*;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [2:0]  func_i  = 3'b000;
    logic [31:0] opa_i   = '0;
    logic [31:0] opb_i   = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    muldiv_iter_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .func_i   (func_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .abort_i  (abort_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            FUNCT3_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            FUNCT3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            FUNCT3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            FUNCT3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            FUNCT3_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb);
                return p[31:0];
            end
            FUNCT3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            FUNCT3_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 0;
        if ((f == FUNCT3_DIV || f == FUNCT3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Issue one op; lat = edges after the start edge before done is seen (-1 on timeout).
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        start_i = 1'b1;
        func_i  = f;
        opa_i   = a;
        opb_i   = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result_o;
        if (lat >= 100) lat = -1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        do_op(f, a, b, res, lat);
        check({name, "_result"}, res, exp);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] ra, rb, res_at_done;
        logic [2:0]  rf;
        int          bcnt, dcnt;

        vecs.push_back(vec_t'{FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32});
        vecs.push_back(vec_t'{FUNCT3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32});
        vecs.push_back(vec_t'{FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32});
        vecs.push_back(vec_t'{FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32});
        vecs.push_back(vec_t'{FUNCT3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32});
        vecs.push_back(vec_t'{FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32});
        vecs.push_back(vec_t'{FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32});
        vecs.push_back(vec_t'{FUNCT3_DIVU,   32'd100,        32'd7,         32'd14,        32});
        vecs.push_back(vec_t'{FUNCT3_REMU,   32'd100,        32'd7,         32'd2,         32});
        vecs.push_back(vec_t'{FUNCT3_DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 32});
        vecs.push_back(vec_t'{FUNCT3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32});
        vecs.push_back(vec_t'{FUNCT3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 0});
        vecs.push_back(vec_t'{FUNCT3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 0});
        vecs.push_back(vec_t'{FUNCT3_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 0});
        vecs.push_back(vec_t'{FUNCT3_REM,    32'd5,          32'd0,         32'd5,         0});
        vecs.push_back(vec_t'{FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0});
        vecs.push_back(vec_t'{FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0});

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(busy_o), 32'd0);
        check("reset_done",   32'(done_o), 32'd0);
        check("reset_result", result_o,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Busy window of a full run, with start pulses in RUN that must be ignored
        @(negedge clk);
        start_i = 1'b1; func_i = FUNCT3_MUL; opa_i = 32'd7; opb_i = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        bcnt = 0; dcnt = 0; res_at_done = '0;
        while (busy_o && bcnt < 100) begin
            bcnt++;
            if (done_o) begin
                dcnt++;
                res_at_done = result_o;
            end
            if (bcnt == 5) begin
                start_i = 1'b1; func_i = FUNCT3_DIVU; opa_i = 32'd100; opb_i = 32'd7;
            end
            if (bcnt == 10) start_i = 1'b0;
            @(posedge clk);
            #1;
        end
        check("busy_cycles",    32'(bcnt), 32'd33);
        check("done_pulses",    32'(dcnt), 32'd1);
        check("result_at_done", res_at_done, 32'hFFFF_FFEB);
        check("result_held",    result_o,    32'hFFFF_FFEB);

        // Abort at cycle 10 of a run
        @(negedge clk);
        start_i = 1'b1; func_i = FUNCT3_DIVU; opa_i = 32'd100; opb_i = 32'd7;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        check("abort_busy",   32'(busy_o), 32'd0);
        check("abort_done",   32'(done_o), 32'd0);
        check("abort_result", result_o,    32'hFFFF_FFEB);
        run_check("after_abort", FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start_i = 1'b1; func_i = FUNCT3_MUL; opa_i = 32'd7; opb_i = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(busy_o), 32'd0);
        check("midrst_done",   32'(done_o), 32'd0);
        check("midrst_result", result_o,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after_rst", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);

        // Random ops against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 16));
                3: rb = -32'($urandom_range(1, 16));
                default: ;
            endcase
            run_check($sformatf("rand%0d_f%0d", n, rf), rf, ra, rb, ref_model(rf, ra, rb), ref_lat(rf, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
